ins_prefetch_mem: RTL and testbench

//  Instruction memory with a built-in sequential prefetcher for the pipelined CPU; it replaces the async-read ROM in IF.

---
 rtl/ins_prefetch_mem_pkg.sv | 12 +
 rtl/ins_mem_ram.sv | 37 +++
 rtl/ins_prefetch_mem.sv | 107 ++++++++++
 tb/tb_ins_prefetch_mem.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_prefetch_mem_pkg.sv
// Shared defaults for the instruction prefetch memory slice.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word and word-address widths
//   DEF_FIFO_DEPTH                  : default prefetch FIFO depth
//   DEF_INIT_FILE                   : default program image name
//   DEF_RESET_ADDR                  : word address fetched first after reset
package ins_prefetch_mem_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam     DEF_INIT_FILE  = "benchmark_ccmb.mif";
  localparam int DEF_RESET_ADDR = 0;
endpackage

// File: rtl/ins_mem_ram.sv
// Program RAM: one write port, one synchronous read port, read-first.
// The store powers up all zeros; the program is written through the load port.
//   clk   : clock
//   we    : write enable, waddr/wdata : write word address/data
//   re    : read enable, raddr : read word address
//   rdata : registered read data (holds when re=0)
module ins_mem_ram
  import ins_prefetch_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter     INIT_FILE  = DEF_INIT_FILE
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Power-up image of the program store.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Both ports use non-blocking updates, so a same-address read on a write
  // edge returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ins_prefetch_mem.sv
// Instruction memory with a sequential prefetcher feeding IF.
// Words are read from a sync RAM at the fetch pointer into a small FIFO; the
// FIFO head is presented as instr/pc. A redirect flushes and restarts fetch.
//   clk, rst                : clock, synchronous active-high reset
//   redirect, redirect_addr : flush prefetch and restart at redirect_addr
//   pop                     : IF consumes the head entry (ignored when empty)
//   valid, instr, pc        : head entry; instr/pc are 0 when valid=0
//   load_we, load_addr, load_data : program-load write port
module ins_prefetch_mem
  import ins_prefetch_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter     INIT_FILE  = DEF_INIT_FILE,
  parameter int RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] RST_FA  = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fa;        // next word address to fetch
  logic [ADDR_WIDTH-1:0] tag;       // address of the read currently in the RAM
  logic                  inflight;  // RAM output holds a word due for the FIFO
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  issue, fill, take;

  // Credit uses pre-pop occupancy plus the inflight read, so a fill can
  // never find the FIFO full.
  assign issue = !rst && !redirect && ((count + CW'(inflight)) < DEPTH_C);
  assign fill  = inflight;
  assign take  = pop && (count != '0);

  ins_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (issue),
    .raddr (fa),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fa       <= RST_FA;
      tag      <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      // The read captured on this edge is dropped by clearing inflight.
      fa       <= redirect_addr;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag <= fa;
        fa  <= fa + 1'b1;
      end
      if (fill) wr_ptr <= wr_ptr + 1'b1;
      if (take) rd_ptr <= rd_ptr + 1'b1;
      case ({fill, take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates everything that reads it.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && fill) begin
      instr_q[wr_ptr] <= rdata;
      pc_q[wr_ptr]    <= tag;
    end
  end

  assign valid = (count != '0);
  assign instr = valid ? instr_q[rd_ptr] : '0;
  assign pc    = valid ? pc_q[rd_ptr]    : '0;
endmodule

// File: tb/tb_ins_prefetch_mem.sv
module tb_ins_prefetch_mem;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MD = 1 << AW;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst, redirect, pop, load_we;
  logic [AW-1:0] redirect_addr, load_addr;
  logic [DW-1:0] load_data;
  logic          valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc;

  int errors = 0;
  int checks = 0;

  ins_prefetch_mem #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FIFO_DEPTH (FD),
    .INIT_FILE  (""), .RESET_ADDR (0)
  ) dut (
    .clk (clk), .rst (rst), .redirect (redirect), .redirect_addr (redirect_addr),
    .pop (pop), .valid (valid), .instr (instr), .pc (pc),
    .load_we (load_we), .load_addr (load_addr), .load_data (load_data)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of fetched words, one pending word captured at
  // the fetch address, and a copy of the program memory.
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] ins; } ent_t;
  ent_t          mq[$];
  ent_t          m_pend, m_np;
  bit            m_pend_v = 0;
  bit            m_iss;
  int            m_fa = 0;
  logic [DW-1:0] m_mem [MD];
  logic          mv = 0;
  logic [AW-1:0] mpc = '0;
  logic [DW-1:0] mins = '0;

  initial for (int i = 0; i < MD; i++) m_mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); m_pend_v = 0; m_fa = 0;
    end else if (redirect) begin
      mq.delete(); m_pend_v = 0; m_fa = int'(redirect_addr);
    end else begin
      m_iss = (mq.size() + int'(m_pend_v)) < FD;
      m_np.pc = AW'(m_fa);
      m_np.ins = m_mem[m_fa];
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (m_pend_v) mq.push_back(m_pend);
      m_pend_v = m_iss;
      if (m_iss) begin m_pend = m_np; m_fa = (m_fa + 1) % MD; end
    end
    if (load_we) m_mem[load_addr] = load_data;
    mv   = mq.size() > 0;
    mpc  = mv ? mq[0].pc  : '0;
    mins = mv ? mq[0].ins : '0;
  end

  task test_reset;
    rst = 1; redirect = 0; redirect_addr = '0; pop = 0;
    for (int i = 0; i < MD; i++) begin
      load_we = 1; load_addr = AW'(i); load_data = 32'h100 + i;
      @(negedge clk);
    end
    load_we = 0; load_addr = '0; load_data = '0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || instr !== '0 || pc !== '0) begin
      errors++;
      $display("FAIL reset got v=%b pc=%h i=%h want v=0 pc=0 i=0", valid, pc, instr);
    end
  endtask

  task test_stream;
    rst = 0; pop = 1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL latency1 got v=%b want v=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 10'h0 || instr !== 32'h100) begin
      errors++; $display("FAIL latency2 got v=%b pc=%h i=%h want v=1 pc=0 i=100", valid, pc, instr);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || pc !== AW'(k) || instr !== 32'h100 + k) begin
        errors++; $display("FAIL stream k=%0d got v=%b pc=%h i=%h want pc=%h i=%h",
                           k, valid, pc, instr, k, 32'h100 + k);
      end
    end
  endtask

  task test_stall;
    pop = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || pc !== 10'd8 || instr !== 32'h108) begin
        errors++; $display("FAIL stall k=%0d got v=%b pc=%h i=%h want v=1 pc=8 i=108", k, valid, pc, instr);
      end
    end
    pop = 1;
    for (int k = 9; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || pc !== AW'(k) || instr !== 32'h100 + k) begin
        errors++; $display("FAIL resume got v=%b pc=%h i=%h want pc=%h", valid, pc, instr, k);
      end
    end
  endtask

  task test_redirect_wrap;
    pop = 0;
    repeat (6) @(negedge clk);
    redirect = 1; redirect_addr = 10'h3FE; pop = 1;
    @(negedge clk);
    redirect = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid !== 1'b0 || pc !== '0 || instr !== '0) begin
        errors++; $display("FAIL redir_gap k=%0d got v=%b pc=%h i=%h want v=0", k, valid, pc, instr);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (valid !== 1'b1 || pc !== AW'((10'h3FE + k) % MD) ||
          instr !== 32'h100 + ((10'h3FE + k) % MD)) begin
        errors++; $display("FAIL redir_wrap k=%0d got v=%b pc=%h i=%h want pc=%h",
                           k, valid, pc, instr, (10'h3FE + k) % MD);
      end
      @(negedge clk);
    end
  endtask

  task test_redirect_pop;
    pop = 0; redirect = 1; redirect_addr = 10'h040;
    @(negedge clk);
    redirect = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 10'h040 || mq.size() != 3) begin
      errors++; $display("FAIL rp_setup got v=%b pc=%h want v=1 pc=040 (model size %0d)", valid, pc, mq.size());
    end
    redirect = 1; redirect_addr = 10'h080; pop = 1;
    @(negedge clk);
    redirect = 0; pop = 0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rp_flush got v=%b want v=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rp_flush2 got v=%b want v=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 10'h080 || instr !== 32'h180) begin
      errors++; $display("FAIL rp_restart got v=%b pc=%h i=%h want pc=080 i=180", valid, pc, instr);
    end
  endtask

  task test_load_hazard;
    pop = 1; redirect = 1; redirect_addr = 10'd5;
    @(negedge clk);
    redirect = 0; load_we = 1; load_addr = 10'd5; load_data = 32'hDEADBEEF;
    @(negedge clk);
    load_we = 0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL ld_gap got v=%b want v=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 10'd5 || instr !== 32'h105) begin
      errors++; $display("FAIL ld_old got v=%b pc=%h i=%h want pc=005 i=105", valid, pc, instr);
    end
    redirect = 1; redirect_addr = 10'd5;
    @(negedge clk);
    redirect = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 10'd5 || instr !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ld_new got v=%b pc=%h i=%h want pc=005 i=deadbeef", valid, pc, instr);
    end
  endtask

  task test_rst_mid;
    pop = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (valid !== 1'b0 || instr !== '0 || pc !== '0) begin
      errors++; $display("FAIL rst_mid got v=%b pc=%h i=%h want all 0", valid, pc, instr);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rst_lat1 got v=%b want v=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== '0 || instr !== 32'h100) begin
      errors++; $display("FAIL rst_lat2 got v=%b pc=%h i=%h want pc=000 i=100", valid, pc, instr);
    end
  endtask

  task test_random;
    for (int k = 0; k < 600; k++) begin
      rst           = ($urandom_range(0, 59) == 0);
      redirect      = ($urandom_range(0, 11) == 0);
      redirect_addr = AW'($urandom);
      pop           = ($urandom_range(0, 3) != 0);
      load_we       = ($urandom_range(0, 7) == 0);
      load_addr     = AW'($urandom);
      load_data     = $urandom;
      @(negedge clk);
      checks++;
      if (valid !== mv || pc !== mpc || instr !== mins) begin
        errors++; $display("FAIL random k=%0d got v=%b pc=%h i=%h want v=%b pc=%h i=%h",
                           k, valid, pc, instr, mv, mpc, mins);
      end
    end
    rst = 0; redirect = 0; pop = 0; load_we = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wrap();
    test_redirect_pop();
    test_load_hazard();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
